dsi_video_scheduler: RTL and testbench
======================================

Name: dsi_video_scheduler

Overview:
Frame/line timing controller that sequences the 24-bit pixel serializer for the DSI video path. It pulls pixels from an upstream pixel source with a valid/ready handshake and issues one load per BPP-cycle pixel slot. It also inserts horizontal and vertical blanking and emits frame/line markers for the packetizer. Timing is free-running once started; a starved source never stretches a line.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
H_BLANK, 16, blanking clock cycles after each active line (>=1)
V_BLANK, 4, blanking line-periods after last active line (>=0)
BPP, 24, bits per pixel = clock cycles per pixel slot

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
enable  in  1  run request; sampled in IDLE and at end of frame
pix_data  in  BPP  upstream pixel
pix_valid  in  1  upstream pixel available
pix_ready  out  1  scheduler accepts pix_data this cycle
ser_load  out  1  one-cycle load strobe to shifter
ser_pixel  out  BPP  pixel loaded with ser_load
line_start  out  1  pulse, first cycle of each active line
frame_start  out  1  pulse, first cycle of active line 0
blanking  out  1  high in IDLE, HBLANK, VBLANK
underflow  out  1  sticky: slot started with pix_valid low

Behaviour:
- Reset (async, rst=1): state IDLE, all counters 0; pix_ready, ser_load, line_start, frame_start, underflow = 0; ser_pixel = 0; blanking = 1.
- LINE_CYCLES = H_ACTIVE*BPP + H_BLANK. Counter widths use $clog2 of the max count; wrap is never relied on.
- States: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE: when enable=1, next cycle enters ACTIVE with line=0, pixel=0, bit=0.
- ACTIVE: bit counter runs 0..BPP-1 per slot.
  - pix_ready is combinational and equals (state==ACTIVE && bit==0).
  - At bit==0 with pix_valid=1: ser_load=1 and ser_pixel=pix_data in the same cycle (registered outputs visible next cycle are not allowed; the strobe is aligned to the slot start).
  - At bit==0 with pix_valid=0: ser_load=1, ser_pixel=0 (black), underflow set, no pixel consumed. Slot timing is unchanged.
  - ser_pixel holds its last value between loads.
  - After the slot with pixel==H_ACTIVE-1 and bit==BPP-1, go to HBLANK.
- HBLANK: lasts exactly H_BLANK cycles. Then:
  - if line<V_ACTIVE-1: line++, go to ACTIVE.
  - else if V_BLANK>0: go to VBLANK.
  - else: take the end-of-frame decision.
- VBLANK: lasts exactly V_BLANK*LINE_CYCLES cycles, then takes the end-of-frame decision.
- End-of-frame decision: enable=1 goes to ACTIVE line 0 (back-to-back frames, no gap); enable=0 goes to IDLE. Deasserting enable mid-frame never truncates the frame.
- line_start: asserted combinationally in the first ACTIVE cycle of each line (pixel=0, bit=0). frame_start: same, additionally qualified by line=0.
- underflow clears only on rst.
- Simultaneous pix_valid with bit!=0 or in blanking: no transfer; upstream holds.
- Latency: pixel accepted at slot start appears on ser_pixel that same cycle. The shifter emits its MSB on the following cycle.

Decomposition:
- Package dsi_video_pkg: state enum (IDLE/ACTIVE/HBLANK/VBLANK), BPP default constant, and a LINE_CYCLES function.
- Sub-module dsi_pixel_shifter: load-strobed BPP-bit MSB-first shift register driven by ser_load/ser_pixel. It is instantiated beside the scheduler in the video top, not inside it.

Test Plan:
Use H_ACTIVE=4, V_ACTIVE=2, H_BLANK=3, V_BLANK=1, BPP=24, giving LINE_CYCLES=99.
1. Reset mid-ACTIVE (rst pulsed at cycle 50) -> same cycle: ser_load=0, blanking=1, state IDLE; underflow cleared.
2. enable=1, pix_valid always 1, data 0x000001..0x000008 -> ser_load at cycles 1,25,49,73, then 100,124,148,172 after entry; pix_ready only on those cycles; frame_start once at cycle 1; line_start at 1 and 100.
3. Same run -> blanking high for cycles 97–99 and 196–297; with enable held, second frame_start at cycle 298 (frame = 297 cycles).
4. pix_valid low at the third slot of line 0 -> ser_pixel=0x000000 at that load, underflow=1 and stays 1. The pixel is not consumed, so the next load delivers the held value 0x000003.
5. Drop enable at cycle 150 (mid line 1) -> frame completes through VBLANK, enters IDLE at cycle 298, no further ser_load.
6. pix_valid asserted only during HBLANK -> pix_ready=0 and no transfer there; the held pixel is accepted at the next line_start cycle.

Source files
------------

// File: rtl/dsi_video_pkg.sv
// Shared types and timing helpers for the DSI video path.
package dsi_video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } state_e;

  localparam int BPP_DEF = 24;

  function automatic int line_cycles(input int h_active, input int bpp, input int h_blank);
    return h_active * bpp + h_blank;
  endfunction

endpackage

// File: rtl/dsi_pixel_shifter.sv
// Load-strobed MSB-first shift register fed by the scheduler's ser_load/ser_pixel.
module dsi_pixel_shifter
  import dsi_video_pkg::*;
#(
  parameter int BPP = BPP_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ser_load,
  input  logic [BPP-1:0] ser_pixel,
  output logic           ser_out
);

  logic [BPP-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = ser_load ? ser_pixel : {sr_q[BPP-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign ser_out = sr_q[BPP-1];

endmodule

// File: rtl/dsi_video_scheduler.sv
// Free-running frame/line timing: one serializer load per BPP-cycle pixel slot,
// horizontal/vertical blanking, and line/frame markers.
module dsi_video_scheduler
  import dsi_video_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 4,
  parameter int BPP      = BPP_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic [BPP-1:0] pix_data,
  input  logic           pix_valid,
  output logic           pix_ready,
  output logic           ser_load,
  output logic [BPP-1:0] ser_pixel,
  output logic           line_start,
  output logic           frame_start,
  output logic           blanking,
  output logic           underflow
);

  localparam int LC      = line_cycles(H_ACTIVE, BPP, H_BLANK);
  localparam int VB_CYC  = V_BLANK * LC;
  localparam int BLK_MAX = (VB_CYC > H_BLANK) ? VB_CYC : H_BLANK;
  localparam int LW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int PW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int BW = (BPP > 1)      ? $clog2(BPP)      : 1;
  localparam int KW = (BLK_MAX > 1)  ? $clog2(BLK_MAX)  : 1;

  localparam logic [LW-1:0] LINE_LAST = LW'(V_ACTIVE - 1);
  localparam logic [PW-1:0] PIX_LAST  = PW'(H_ACTIVE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BPP - 1);
  localparam logic [KW-1:0] HB_LAST   = KW'(H_BLANK - 1);
  // VBLANK is unreachable when V_BLANK==0; keep the constant non-negative anyway.
  localparam logic [KW-1:0] VB_LAST   = KW'(((VB_CYC > 0) ? VB_CYC : 1) - 1);

  state_e         state_q, state_d;
  logic [LW-1:0]  line_q, line_d;
  logic [PW-1:0]  pixel_q, pixel_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [KW-1:0]  blk_q, blk_d;
  logic [BPP-1:0] hold_q, hold_d;
  logic           under_q, under_d;
  logic           slot, eof;

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    pixel_d = pixel_q;
    bit_d   = bit_q;
    blk_d   = blk_q;
    eof     = 1'b0;

    // Slot start: the load strobe and the upstream handshake share this cycle.
    slot        = (state_q == ST_ACTIVE) && (bit_q == '0);
    pix_ready   = slot;
    ser_load    = slot;
    ser_pixel   = slot ? (pix_valid ? pix_data : '0) : hold_q;
    hold_d      = ser_pixel;
    under_d     = under_q | (slot & ~pix_valid);
    underflow   = under_d;
    line_start  = slot && (pixel_q == '0);
    frame_start = line_start && (line_q == '0);
    blanking    = (state_q != ST_ACTIVE);

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_ACTIVE;
          line_d  = '0;
          pixel_d = '0;
          bit_d   = '0;
        end
      end
      ST_ACTIVE: begin
        if (bit_q == BIT_LAST) begin
          bit_d = '0;
          if (pixel_q == PIX_LAST) begin
            pixel_d = '0;
            blk_d   = '0;
            state_d = ST_HBLANK;
          end else begin
            pixel_d = pixel_q + PW'(1);
          end
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      ST_HBLANK: begin
        if (blk_q == HB_LAST) begin
          blk_d = '0;
          if (line_q != LINE_LAST) begin
            line_d  = line_q + LW'(1);
            state_d = ST_ACTIVE;
          end else if (V_BLANK > 0) begin
            state_d = ST_VBLANK;
          end else begin
            eof = 1'b1;
          end
        end else begin
          blk_d = blk_q + KW'(1);
        end
      end
      ST_VBLANK: begin
        if (blk_q == VB_LAST) begin
          blk_d = '0;
          eof   = 1'b1;
        end else begin
          blk_d = blk_q + KW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // enable is only honoured at frame boundaries, so frames are never cut short.
    if (eof) begin
      line_d  = '0;
      pixel_d = '0;
      bit_d   = '0;
      state_d = enable ? ST_ACTIVE : ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      line_q  <= '0;
      pixel_q <= '0;
      bit_q   <= '0;
      blk_q   <= '0;
      hold_q  <= '0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      pixel_q <= pixel_d;
      bit_q   <= bit_d;
      blk_q   <= blk_d;
      hold_q  <= hold_d;
      under_q <= under_d;
    end
  end

endmodule

// File: tb/tb_dsi_video_scheduler.sv
// Bench for dsi_video_scheduler with the pixel shifter beside it; frame-position reference model.
module tb_dsi_video_scheduler;
  localparam int H_ACTIVE = 4;
  localparam int V_ACTIVE = 2;
  localparam int H_BLANK  = 3;
  localparam int V_BLANK  = 1;
  localparam int BPP      = 24;
  localparam int LC       = H_ACTIVE * BPP + H_BLANK;
  localparam int FRAME    = (V_ACTIVE + V_BLANK) * LC;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           enable = 1'b0;
  logic [BPP-1:0] pix_data = '0;
  logic           pix_valid = 1'b0;
  logic           pix_ready, ser_load, line_start, frame_start, blanking, underflow, ser_out;
  logic [BPP-1:0] ser_pixel;

  dsi_video_scheduler #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK), .V_BLANK(V_BLANK), .BPP(BPP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .ser_load(ser_load), .ser_pixel(ser_pixel),
    .line_start(line_start), .frame_start(frame_start), .blanking(blanking), .underflow(underflow)
  );

  dsi_pixel_shifter #(.BPP(BPP)) u_shift (
    .clk(clk), .rst(rst), .ser_load(ser_load), .ser_pixel(ser_pixel), .ser_out(ser_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: running flag plus cycle offset inside the frame.
  logic           m_run, m_under, e_slot, m_acc;
  int             m_t;
  logic [BPP-1:0] m_last, m_sr, e_pix;

  typedef struct {
    int             cyc;
    logic           ld;
    logic           ls;
    logic           fs;
    logic           bl;
    logic [BPP-1:0] px;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_under = 1'b0; m_t = 0; m_last = '0; m_sr = '0;
  endtask

  task automatic model_check();
    int ln, pos;
    logic e_act, e_ls, e_fs, e_un;
    ln     = m_t / LC;
    pos    = m_t % LC;
    e_act  = m_run && (ln < V_ACTIVE) && (pos < H_ACTIVE * BPP);
    e_slot = e_act && (pos % BPP == 0);
    e_pix  = e_slot ? (pix_valid ? pix_data : '0) : m_last;
    e_ls   = e_slot && (pos == 0);
    e_fs   = e_ls && (m_t == 0);
    e_un   = m_under || (e_slot && !pix_valid);
    chk("model", 64'({pix_ready, ser_load, ser_pixel, line_start, frame_start, blanking, underflow, ser_out}),
                 64'({e_slot, e_slot, e_pix, e_ls, e_fs, !e_act, e_un, m_sr[BPP-1]}));
  endtask

  task automatic drive(input logic en, input logic v, input logic [BPP-1:0] d);
    @(negedge clk);
    enable = en; pix_valid = v; pix_data = d;
    #1;
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    m_acc = e_slot && pix_valid;
    if (e_slot) begin
      m_last = e_pix;
      if (!pix_valid) m_under = 1'b1;
    end
    m_sr = e_slot ? e_pix : (m_sr << 1);
    if (!m_run) begin
      if (enable) begin m_run = 1'b1; m_t = 0; end
    end else if (m_t == FRAME - 1) begin
      if (enable) m_t = 0; else m_run = 1'b0;
    end else begin
      m_t++;
    end
    cyc++;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; enable = 1'b0; pix_valid = 1'b0;
    #1;
    chk("rst_outputs", 64'({ser_load, pix_ready, line_start, frame_start, blanking, underflow, ser_pixel}),
                       64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0}));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    logic [BPP-1:0] src, cur;
    int idx, loads;

    tbl[0]  = '{0,   1'b0, 1'b0, 1'b0, 1'b1, 24'h0};
    tbl[1]  = '{1,   1'b1, 1'b1, 1'b1, 1'b0, 24'h1};
    tbl[2]  = '{2,   1'b0, 1'b0, 1'b0, 1'b0, 24'h1};
    tbl[3]  = '{25,  1'b1, 1'b0, 1'b0, 1'b0, 24'h2};
    tbl[4]  = '{49,  1'b1, 1'b0, 1'b0, 1'b0, 24'h3};
    tbl[5]  = '{73,  1'b1, 1'b0, 1'b0, 1'b0, 24'h4};
    tbl[6]  = '{96,  1'b0, 1'b0, 1'b0, 1'b0, 24'h4};
    tbl[7]  = '{97,  1'b0, 1'b0, 1'b0, 1'b1, 24'h4};
    tbl[8]  = '{99,  1'b0, 1'b0, 1'b0, 1'b1, 24'h4};
    tbl[9]  = '{100, 1'b1, 1'b1, 1'b0, 1'b0, 24'h5};
    tbl[10] = '{172, 1'b1, 1'b0, 1'b0, 1'b0, 24'h8};
    tbl[11] = '{196, 1'b0, 1'b0, 1'b0, 1'b1, 24'h8};
    tbl[12] = '{297, 1'b0, 1'b0, 1'b0, 1'b1, 24'h8};
    tbl[13] = '{298, 1'b1, 1'b1, 1'b1, 1'b0, 24'h9};

    model_reset();
    pulse_reset();

    // Back-to-back frames, source always ready, checked against the vector table.
    src = 24'h1; idx = 0;
    while (cyc <= 300) begin
      drive(1'b1, 1'b1, src);
      if (idx < 14 && tbl[idx].cyc == cyc) begin
        chk("vec", 64'({pix_ready, ser_load, line_start, frame_start, blanking, ser_pixel}),
                   64'({tbl[idx].ld, tbl[idx].ld, tbl[idx].ls, tbl[idx].fs, tbl[idx].bl, tbl[idx].px}));
        idx++;
      end
      advance();
      if (m_acc) src++;
    end

    // Starved third slot: black load, sticky underflow, pixel held for the next slot.
    pulse_reset();
    src = 24'h1;
    while (cyc <= 120) begin
      drive(1'b1, cyc != 49, src);
      if (cyc == 49)  chk("uf_black", 64'({ser_load, ser_pixel}), 64'({1'b1, 24'h0}));
      if (cyc == 50)  chk("uf_set", 64'(underflow), 64'(1'b1));
      if (cyc == 73)  chk("uf_held_pix", 64'({ser_load, ser_pixel}), 64'({1'b1, 24'h3}));
      if (cyc == 120) chk("uf_sticky", 64'(underflow), 64'(1'b1));
      advance();
      if (m_acc) src++;
    end

    // Reset mid-ACTIVE clears state and underflow immediately.
    pulse_reset();
    while (cyc < 50) begin drive(1'b1, 1'b0, 24'h0); advance(); end
    drive(1'b1, 1'b0, 24'h0);
    chk("pre_rst_active", 64'({blanking, underflow}), 64'({1'b0, 1'b1}));
    pulse_reset();

    // enable dropped mid line 1: frame completes, then IDLE with no loads.
    src = 24'h10; loads = 0;
    while (cyc <= 400) begin
      drive(cyc < 150, 1'b1, src);
      if (cyc == 297) chk("en_drop_vblank", 64'(blanking), 64'(1'b1));
      if (cyc == 298) chk("en_drop_idle", 64'({blanking, ser_load, frame_start}), 64'({1'b1, 1'b0, 1'b0}));
      if (cyc >= 298 && ser_load) loads++;
      advance();
      if (m_acc) src++;
    end
    chk("no_load_after_idle", 64'(loads), 64'(0));

    // Valid only from HBLANK on: no transfer there, accepted at the next line_start.
    pulse_reset();
    while (cyc <= 102) begin
      drive(1'b1, cyc >= 97 && cyc <= 100, 24'hABCDEF);
      if (cyc == 98) chk("hb_no_ready", 64'({pix_ready, ser_load}), 64'({1'b0, 1'b0}));
      if (cyc == 100) chk("hb_accept", 64'({pix_ready, line_start, ser_pixel}), 64'({1'b1, 1'b1, 24'hABCDEF}));
      if (cyc == 101) chk("shift_msb", 64'(ser_out), 64'(1'b1));
      advance();
    end

    // Randomized run against the model; upstream holds data until accepted.
    pulse_reset();
    cur = BPP'($urandom);
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 99) < 92, $urandom_range(0, 9) < 8, cur);
      if ($urandom_range(0, 1499) == 0) begin
        pulse_reset();
        continue;
      end
      advance();
      if (m_acc || !pix_valid) cur = BPP'($urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
